// File: rtl/leg_fetch_unit.sv
// Instruction fetch unit: reads a 4-byte instruction one byte per cycle from
// program memory and presents it to the decoder with a valid/ready handshake.
module leg_fetch_unit #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    input  logic       branch_en,
    input  logic [7:0] branch_target,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] arg1,
    output logic [7:0] arg2,
    output logic [7:0] result,
    output logic [7:0] pc
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_CAPT  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t     state_p0;
    logic [1:0] k_p0;
    logic       vld_p1;
    logic [1:0] idx_p1;
    logic       transfer;
    logic [7:0] branch_pc;

    // No child instances exist yet; a negative UUID would corrupt derived IDs.
    if (UUID < 0 && $bits(NAME) >= 0) begin : g_param_chk
        $error("leg_fetch_unit: UUID must be non-negative");
    end

    assign transfer  = (state_p0 == ST_VALID) && instr_ready;
    assign branch_pc = {branch_target[7:2], 2'b00};
    assign mem_rd    = rst && (state_p0 == ST_ISSUE);
    assign mem_addr  = (state_p0 == ST_ISSUE) ? (pc + {6'd0, k_p0}) : pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p0    <= ST_ISSUE;
            k_p0        <= 2'd0;
            pc          <= 8'h00;
            instr_valid <= 1'b0;
            vld_p1      <= 1'b0;
            idx_p1      <= 2'd0;
            opcode      <= 8'h00;
            arg1        <= 8'h00;
            arg2        <= 8'h00;
            result      <= 8'h00;
        end else begin
            // Stage 1: byte returned for the previous cycle's issue
            if (vld_p1 && !branch_en) begin
                case (idx_p1)
                    2'd0:    opcode <= mem_data;
                    2'd1:    arg1   <= mem_data;
                    2'd2:    arg2   <= mem_data;
                    default: result <= mem_data;
                endcase
            end

            // Stage 0: issue sequencing and handshake
            vld_p1 <= 1'b0;
            if (branch_en) begin
                pc          <= branch_pc;
                state_p0    <= ST_ISSUE;
                k_p0        <= 2'd0;
                instr_valid <= 1'b0;
            end else begin
                case (state_p0)
                    ST_ISSUE: begin
                        vld_p1 <= 1'b1;
                        idx_p1 <= k_p0;
                        k_p0   <= k_p0 + 2'd1;
                        if (k_p0 == 2'd3)
                            state_p0 <= ST_CAPT;
                    end
                    ST_CAPT: begin
                        state_p0    <= ST_VALID;
                        instr_valid <= 1'b1;
                    end
                    ST_VALID: begin
                        if (transfer) begin
                            pc          <= pc + 8'd4;
                            state_p0    <= ST_ISSUE;
                            k_p0        <= 2'd0;
                            instr_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state_p0    <= ST_ISSUE;
                        k_p0        <= 2'd0;
                        instr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_leg_fetch_unit.sv
// Bench for leg_fetch_unit: a byte memory, a timeline model of the fetch
// sequence checked every cycle, and directed scenarios with literal values.
module tb_leg_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       branch_en;
    logic [7:0] branch_target;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode, arg1, arg2, result, pc;

    leg_fetch_unit #(.UUID(0), .NAME("fetch0")) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .arg1          (arg1),
        .arg2          (arg2),
        .result        (result),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];

    always @(posedge clk) begin
        if (mem_rd === 1'b1)
            mem_data <= mem[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    // Model: an instruction fetch started at m_pc is 'age' cycles old; bytes
    // are requested at ages 0..3 and the instruction is presented from age 5.
    bit         m_known = 1'b0;
    logic [7:0] m_pc;
    int         m_age;
    int         dut_xfer = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic [7:0] a;
        @(negedge clk);
        if (m_known) begin
            chk("mdl_mem_rd", 8'(mem_rd), 8'(rst === 1'b1 && m_age < 4));
            chk("mdl_mem_addr", mem_addr, (m_age < 4) ? 8'(m_pc + 8'(m_age)) : m_pc);
            chk("mdl_instr_valid", 8'(instr_valid), 8'(m_age >= 5));
            chk("mdl_pc", pc, m_pc);
            if (m_age >= 5) begin
                a = m_pc;
                chk("mdl_opcode", opcode, mem[a]);
                a = m_pc + 8'd1;
                chk("mdl_arg1", arg1, mem[a]);
                a = m_pc + 8'd2;
                chk("mdl_arg2", arg2, mem[a]);
                a = m_pc + 8'd3;
                chk("mdl_result", result, mem[a]);
            end
        end
        if (instr_valid === 1'b1 && instr_ready === 1'b1)
            dut_xfer++;
        if (rst === 1'b0) begin
            m_known = 1'b1;
            m_pc    = 8'h00;
            m_age   = 0;
        end else if (m_known) begin
            if (branch_en) begin
                m_pc  = branch_target & 8'hFC;
                m_age = 0;
            end else if (m_age >= 5 && instr_ready) begin
                m_pc  = m_pc + 8'd4;
                m_age = 0;
            end else if (m_age < 5) begin
                m_age++;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    task automatic wait_valid(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (instr_valid === 1'b1) seen = 1'b1;
            else adv();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: instr_valid got 0 expected 1 within 20 cycles", nm);
        end
    endtask

    logic [7:0] h_op, h_a1, h_a2, h_res, h_pc;
    int         x0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h40; mem[1] = 8'h05; mem[2] = 8'h07; mem[3] = 8'h02;
        rst = 1'b0; branch_en = 1'b0; branch_target = 8'h00; instr_ready = 1'b1;

        // Reset state
        run(3);
        sample();
        chk("rst_mem_rd", 8'(mem_rd), 8'd0);
        chk("rst_valid", 8'(instr_valid), 8'd0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_opcode", opcode, 8'h00);
        chk("rst_arg1", arg1, 8'h00);
        chk("rst_arg2", arg2, 8'h00);
        chk("rst_result", result, 8'h00);
        adv();

        // First fetch after release
        rst = 1'b1;
        sample();
        chk("first_addr", mem_addr, 8'h00);
        chk("first_rd", 8'(mem_rd), 8'd1);
        adv();
        run(4);
        sample();
        chk("c6_valid", 8'(instr_valid), 8'd1);
        chk("c6_opcode", opcode, 8'h40);
        chk("c6_arg1", arg1, 8'h05);
        chk("c6_arg2", arg2, 8'h07);
        chk("c6_result", result, 8'h02);
        chk("c6_pc", pc, 8'h00);
        adv();
        sample();
        chk("next_addr", mem_addr, 8'h04);
        chk("next_pc", pc, 8'h04);
        chk("next_valid", 8'(instr_valid), 8'd0);
        adv();

        // Stall in VALID for 10 cycles
        instr_ready = 1'b0;
        wait_valid("stall_wait");
        h_op = opcode; h_a1 = arg1; h_a2 = arg2; h_res = result; h_pc = pc;
        chk("stall_pc", h_pc, 8'h04);
        chk("stall_opcode", h_op, 8'h5E);
        for (int i = 0; i < 10; i++) begin
            adv();
            sample();
            chk("stall_hold_valid", 8'(instr_valid), 8'd1);
            chk("stall_hold_rd", 8'(mem_rd), 8'd0);
            chk("stall_hold_pc", pc, h_pc);
            chk("stall_hold_opcode", opcode, h_op);
            chk("stall_hold_arg1", arg1, h_a1);
            chk("stall_hold_arg2", arg2, h_a2);
            chk("stall_hold_result", result, h_res);
        end
        adv();
        instr_ready = 1'b1;
        x0 = dut_xfer;
        sample();
        adv();
        sample();
        chk("stall_accept_cnt", 8'(dut_xfer - x0), 8'd1);
        chk("stall_after_pc", pc, 8'h08);
        chk("stall_after_addr", mem_addr, 8'h08);
        adv();

        // Branch while k=2
        sample();
        adv();
        branch_en = 1'b1; branch_target = 8'h23;
        sample();
        chk("br_k2_addr", mem_addr, 8'h0A);
        adv();
        branch_en = 1'b0;
        sample();
        chk("br_new_addr", mem_addr, 8'h20);
        chk("br_new_pc", pc, 8'h20);
        chk("br_new_rd", 8'(mem_rd), 8'd1);
        adv();
        wait_valid("br_wait");
        chk("br_opcode", opcode, 8'h7A);
        chk("br_result", result, 8'h79);
        chk("br_pc", pc, 8'h20);
        adv();

        // pc wrap from 0xFC
        branch_en = 1'b1; branch_target = 8'hFE;
        sample();
        adv();
        branch_en = 1'b0;
        wait_valid("wrap_wait");
        chk("wrap_pc_fc", pc, 8'hFC);
        chk("wrap_opcode", opcode, 8'hA6);
        for (int i = 0; i < 4; i++) begin
            adv();
            sample();
            chk("wrap_addr_seq", mem_addr, 8'(i));
            chk("wrap_pc", pc, 8'h00);
        end
        adv();
        sample();
        adv();

        // Transfer and branch in the same cycle
        branch_en = 1'b1; branch_target = 8'h10;
        x0 = dut_xfer;
        sample();
        chk("tb_same_valid", 8'(instr_valid), 8'd1);
        chk("tb_same_pc", pc, 8'h00);
        adv();
        branch_en = 1'b0; instr_ready = 1'b0;
        sample();
        chk("tb_same_after_valid", 8'(instr_valid), 8'd0);
        chk("tb_same_after_pc", pc, 8'h10);
        adv();
        wait_valid("tb_same_wait");
        chk("tb_same_consumed", 8'(dut_xfer - x0), 8'd1);
        chk("tb_same_opcode", opcode, 8'h4A);

        // Branch drops a held instruction
        adv();
        branch_en = 1'b1; branch_target = 8'h31;
        x0 = dut_xfer;
        sample();
        adv();
        branch_en = 1'b0;
        sample();
        chk("drop_valid", 8'(instr_valid), 8'd0);
        chk("drop_pc", pc, 8'h30);
        chk("drop_cnt", 8'(dut_xfer - x0), 8'd0);
        adv();

        // Reset pulse during CAPT
        run(3);
        rst = 1'b0;
        sample();
        chk("capt_rd", 8'(mem_rd), 8'd0);
        chk("capt_valid", 8'(instr_valid), 8'd0);
        adv();
        rst = 1'b1;
        sample();
        chk("rst2_valid", 8'(instr_valid), 8'd0);
        chk("rst2_pc", pc, 8'h00);
        chk("rst2_addr", mem_addr, 8'h00);
        chk("rst2_rd", 8'(mem_rd), 8'd1);
        chk("rst2_opcode", opcode, 8'h00);
        adv();
        instr_ready = 1'b1;
        wait_valid("rst2_wait");
        chk("rst2_final_pc", pc, 8'h00);
        chk("rst2_final_opcode", opcode, 8'h40);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
